// File: rtl/instruction_control.sv
// -----------------------------------------------------------------------------
// instruction_control
//
// Instruction register and microcode step sequencer for the 8-bit bus computer.
// The instruction word is latched from the shared bus at the end of fetch
// (T1). A step counter walks T0..T4, and the opcode/step pair is decoded into
// the control strobes used by the PC, MAR/RAM, A/B/ALU and output register.
// For address, immediate and jump steps the operand nibble is driven back
// onto the bus.
//
// Parameters:
//   NUM_STEPS  T-states per instruction (step counter is 3 bits wide)
//   EARLY_END  1: wrap to T0 after the opcode's last active step
//              0: always run T0..NUM_STEPS-1
//
// Ports:
//   clock       system clock, rising edge
//   reset_btn   asynchronous active-low reset
//   bus         shared 8-bit data bus, driven only while IO=1
//   carry_flag  ALU carry flag (sampled during T2 only)
//   zero_flag   ALU zero flag  (sampled during T2 only)
//   CO..OI      control strobes, combinational from step/ir/flags/halt
//   HLT         halt, held high until reset
//   step        current T-state (debug)
//   opcode      ir[7:4] (debug)
// -----------------------------------------------------------------------------
module instruction_control #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b0
) (
    input  logic       clock,
    input  logic       reset_btn,
    inout  wire  [7:0] bus,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       CO,
    output logic       CE,
    output logic       J,
    output logic       MI,
    output logic       RI,
    output logic       RO,
    output logic       II,
    output logic       IO,
    output logic       AI,
    output logic       AO,
    output logic       EO,
    output logic       SU,
    output logic       BI,
    output logic       OI,
    output logic       HLT,
    output logic [2:0] step,
    output logic [3:0] opcode
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    localparam logic [2:0] FINAL_STEP = 3'(NUM_STEPS - 1);

    logic [7:0] ir_reg;
    logic [2:0] step_reg;
    logic [2:0] step_next;
    logic       halted_reg;
    logic [2:0] last_step;
    opcode_t    op;
    opcode_t    end_op;

    assign op     = opcode_t'(ir_reg[7:4]);
    assign step   = step_reg;
    assign opcode = ir_reg[7:4];

    // Operand nibble goes back onto the bus for address/immediate/jump steps.
    assign bus = IO ? {4'b0000, ir_reg[3:0]} : 8'hzz;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            ir_reg     <= 8'h00;
            step_reg   <= 3'd0;
            halted_reg <= 1'b0;
        end else begin
            if (II) begin
                ir_reg <= bus;
            end
            if (HLT) begin
                halted_reg <= 1'b1;
            end
            step_reg <= step_next;
        end
    end

    // -------------------------------------------------------------------------
    // Last active step of the executing opcode. During T1 the new instruction
    // is still on the bus (ir only captures it on this edge), so the decision
    // whether a NOP-class opcode ends at T1 must look at the bus directly.
    // -------------------------------------------------------------------------
    always_comb begin
        end_op    = (step_reg == 3'd1) ? opcode_t'(bus[7:4]) : op;
        last_step = 3'd1;
        case (end_op)
            OP_LDA, OP_STA:                          last_step = 3'd3;
            OP_ADD, OP_SUB:                          last_step = 3'd4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                          last_step = 3'd2;
            default:                                 last_step = 3'd1;
        endcase
    end

    // HLT (first assertion at T2 or held while halted) freezes the counter.
    always_comb begin
        step_next = step_reg + 3'd1;
        if (HLT) begin
            step_next = step_reg;
        end else if (EARLY_END && (step_reg == last_step)) begin
            step_next = 3'd0;
        end else if (step_reg == FINAL_STEP) begin
            step_next = 3'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Microcode decode. Everything is forced low while reset is held so that
    // no consumer sees fetch strobes before the machine is released.
    // -------------------------------------------------------------------------
    always_comb begin
        CO  = 1'b0;
        CE  = 1'b0;
        J   = 1'b0;
        MI  = 1'b0;
        RI  = 1'b0;
        RO  = 1'b0;
        II  = 1'b0;
        IO  = 1'b0;
        AI  = 1'b0;
        AO  = 1'b0;
        EO  = 1'b0;
        SU  = 1'b0;
        BI  = 1'b0;
        OI  = 1'b0;
        HLT = 1'b0;
        if (reset_btn) begin
            if (halted_reg) begin
                HLT = 1'b1;
            end else begin
                case (step_reg)
                    3'd0: begin
                        CO = 1'b1;
                        MI = 1'b1;
                    end
                    3'd1: begin
                        RO = 1'b1;
                        II = 1'b1;
                        CE = 1'b1;
                    end
                    3'd2: begin
                        case (op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                IO = 1'b1;
                                MI = 1'b1;
                            end
                            OP_LDI: begin
                                IO = 1'b1;
                                AI = 1'b1;
                            end
                            OP_JMP: begin
                                IO = 1'b1;
                                J  = 1'b1;
                            end
                            OP_JC: begin
                                IO = carry_flag;
                                J  = carry_flag;
                            end
                            OP_JZ: begin
                                IO = zero_flag;
                                J  = zero_flag;
                            end
                            OP_OUT: begin
                                AO = 1'b1;
                                OI = 1'b1;
                            end
                            OP_HLT: HLT = 1'b1;
                            default: ;
                        endcase
                    end
                    3'd3: begin
                        case (op)
                            OP_LDA: begin
                                RO = 1'b1;
                                AI = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                RO = 1'b1;
                                BI = 1'b1;
                            end
                            OP_STA: begin
                                AO = 1'b1;
                                RI = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    3'd4: begin
                        case (op)
                            OP_ADD: begin
                                EO = 1'b1;
                                AI = 1'b1;
                            end
                            OP_SUB: begin
                                EO = 1'b1;
                                AI = 1'b1;
                                SU = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_control.sv
// -----------------------------------------------------------------------------
// tb_instruction_control
//
// Two instances: dut0 runs every instruction T0..T4, dut1 ends each opcode
// early. The bench plays RAM: whenever a DUT asserts RO, its bus carries
// ram_data. Directed vectors, hand sequences for halt/reset corners and a
// randomized instruction stream checked against a microcode table model.
// -----------------------------------------------------------------------------
module tb_instruction_control;

    localparam logic [14:0] M_CO  = 15'h4000;
    localparam logic [14:0] M_CE  = 15'h2000;
    localparam logic [14:0] M_J   = 15'h1000;
    localparam logic [14:0] M_MI  = 15'h0800;
    localparam logic [14:0] M_RI  = 15'h0400;
    localparam logic [14:0] M_RO  = 15'h0200;
    localparam logic [14:0] M_II  = 15'h0100;
    localparam logic [14:0] M_IO  = 15'h0080;
    localparam logic [14:0] M_AI  = 15'h0040;
    localparam logic [14:0] M_AO  = 15'h0020;
    localparam logic [14:0] M_EO  = 15'h0010;
    localparam logic [14:0] M_SU  = 15'h0008;
    localparam logic [14:0] M_BI  = 15'h0004;
    localparam logic [14:0] M_OI  = 15'h0002;
    localparam logic [14:0] M_HLT = 15'h0001;

    logic       clock = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [7:0] ram_data = 8'h00;
    logic       carry = 1'b0;
    logic       zero = 1'b0;
    wire  [7:0] bus0;
    wire  [7:0] bus1;
    wire [14:0] ctrl0;
    wire [14:0] ctrl1;
    wire  [2:0] step0;
    wire  [2:0] step1;
    wire  [3:0] opc0;
    wire  [3:0] opc1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign bus0 = ctrl0[9] ? ram_data : 8'hzz;
    assign bus1 = ctrl1[9] ? ram_data : 8'hzz;

    instruction_control #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut0 (
        .clock(clock), .reset_btn(rst_n[0]), .bus(bus0),
        .carry_flag(carry), .zero_flag(zero),
        .CO(ctrl0[14]), .CE(ctrl0[13]), .J(ctrl0[12]), .MI(ctrl0[11]),
        .RI(ctrl0[10]), .RO(ctrl0[9]), .II(ctrl0[8]), .IO(ctrl0[7]),
        .AI(ctrl0[6]), .AO(ctrl0[5]), .EO(ctrl0[4]), .SU(ctrl0[3]),
        .BI(ctrl0[2]), .OI(ctrl0[1]), .HLT(ctrl0[0]),
        .step(step0), .opcode(opc0)
    );

    instruction_control #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut1 (
        .clock(clock), .reset_btn(rst_n[1]), .bus(bus1),
        .carry_flag(carry), .zero_flag(zero),
        .CO(ctrl1[14]), .CE(ctrl1[13]), .J(ctrl1[12]), .MI(ctrl1[11]),
        .RI(ctrl1[10]), .RO(ctrl1[9]), .II(ctrl1[8]), .IO(ctrl1[7]),
        .AI(ctrl1[6]), .AO(ctrl1[5]), .EO(ctrl1[4]), .SU(ctrl1[3]),
        .BI(ctrl1[2]), .OI(ctrl1[1]), .HLT(ctrl1[0]),
        .step(step1), .opcode(opc1)
    );

    function automatic logic [14:0] get_ctrl(input int sel);
        return (sel == 0) ? ctrl0 : ctrl1;
    endfunction
    function automatic logic [2:0] get_step(input int sel);
        return (sel == 0) ? step0 : step1;
    endfunction
    function automatic logic [3:0] get_opc(input int sel);
        return (sel == 0) ? opc0 : opc1;
    endfunction
    function automatic logic [7:0] get_bus(input int sel);
        return (sel == 0) ? bus0 : bus1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // An undriven bus reads as z in a 4-state simulator and 0 in a 2-state one.
    task automatic chk_hiz(input string name, input logic [7:0] v);
        checks++;
        if (!((v === 8'hzz) || (v === 8'h00))) begin
            failures++;
            $display("FAIL %s: got %h expected high-Z", name, v);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: per-opcode microcode table for T2..T4 plus the last
    // active step used when instructions end early.
    // ---------------------------------------------------------------------
    logic [14:0] ucode [16][3];
    int          last_t [16];

    task automatic fill_model();
        for (int o = 0; o < 16; o++) begin
            for (int k = 0; k < 3; k++) ucode[o][k] = '0;
            last_t[o] = 1;
        end
        ucode[1]  = '{M_IO | M_MI, M_RO | M_AI, 15'h0};        last_t[1]  = 3;
        ucode[2]  = '{M_IO | M_MI, M_RO | M_BI, M_EO | M_AI};  last_t[2]  = 4;
        ucode[3]  = '{M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_SU}; last_t[3] = 4;
        ucode[4]  = '{M_IO | M_MI, M_AO | M_RI, 15'h0};        last_t[4]  = 3;
        ucode[5]  = '{M_IO | M_AI, 15'h0, 15'h0};              last_t[5]  = 2;
        ucode[6]  = '{M_IO | M_J, 15'h0, 15'h0};               last_t[6]  = 2;
        ucode[7]  = '{M_IO | M_J, 15'h0, 15'h0};               last_t[7]  = 2;
        ucode[8]  = '{M_IO | M_J, 15'h0, 15'h0};               last_t[8]  = 2;
        ucode[14] = '{M_AO | M_OI, 15'h0, 15'h0};              last_t[14] = 2;
        ucode[15] = '{M_HLT, 15'h0, 15'h0};                    last_t[15] = 2;
    endtask

    function automatic logic [14:0] model_ctrl(input int op, input int t, input logic c, input logic z);
        logic [14:0] m;
        if (t == 0) return M_CO | M_MI;
        if (t == 1) return M_RO | M_II | M_CE;
        m = ucode[op][t-2];
        if ((op == 7 && !c) || (op == 8 && !z)) m = '0;
        return m;
    endfunction

    function automatic int model_len(input int op, input int sel);
        return (sel == 1) ? last_t[op] + 1 : 5;
    endfunction

    // ---------------------------------------------------------------------
    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    // Hold both DUTs in reset for a cycle, release only the selected one.
    task automatic start(input int sel);
        rst_n = 2'b00;
        @(negedge clock);
        rst_n[sel] = 1'b1;
        #1;
    endtask

    typedef struct {
        int          sel;
        logic [7:0]  instr;
        logic        c;
        logic        z;
        int          t;
        logic [14:0] exp_ctrl;
        logic [2:0]  exp_step;
        logic [7:0]  exp_bus;
        logic        hiz;
    } vec_t;

    vec_t vecs[13];

    initial begin
        fill_model();
        vecs[0]  = '{0, 8'h1E, 1'b0, 1'b0, 2, M_IO | M_MI,        3'd2, 8'h0E, 1'b0};
        vecs[1]  = '{0, 8'h1E, 1'b0, 1'b0, 3, M_RO | M_AI,        3'd3, 8'h1E, 1'b0};
        vecs[2]  = '{0, 8'h1E, 1'b0, 1'b0, 4, 15'h0,              3'd4, 8'h00, 1'b1};
        vecs[3]  = '{1, 8'h3F, 1'b0, 1'b0, 4, M_EO | M_AI | M_SU, 3'd4, 8'h00, 1'b1};
        vecs[4]  = '{1, 8'h57, 1'b0, 1'b0, 2, M_IO | M_AI,        3'd2, 8'h07, 1'b0};
        vecs[5]  = '{0, 8'h7A, 1'b0, 1'b1, 2, 15'h0,              3'd2, 8'h00, 1'b1};
        vecs[6]  = '{0, 8'h7A, 1'b1, 1'b0, 2, M_IO | M_J,         3'd2, 8'h0A, 1'b0};
        vecs[7]  = '{1, 8'h83, 1'b0, 1'b1, 2, M_IO | M_J,         3'd2, 8'h03, 1'b0};
        vecs[8]  = '{0, 8'h4C, 1'b0, 1'b0, 3, M_AO | M_RI,        3'd3, 8'h00, 1'b1};
        vecs[9]  = '{0, 8'hE5, 1'b0, 1'b0, 2, M_AO | M_OI,        3'd2, 8'h00, 1'b1};
        vecs[10] = '{0, 8'h2B, 1'b0, 1'b0, 4, M_EO | M_AI,        3'd4, 8'h00, 1'b1};
        vecs[11] = '{1, 8'h9D, 1'b0, 1'b0, 2, M_CO | M_MI,        3'd0, 8'h00, 1'b1};
        vecs[12] = '{0, 8'h83, 1'b1, 1'b0, 2, 15'h0,              3'd2, 8'h00, 1'b1};

        // Reset state: outputs quiet and bus released while held in reset.
        #2;
        chk("reset ctrl0", 32'(ctrl0), 32'h0);
        chk("reset ctrl1", 32'(ctrl1), 32'h0);
        chk("reset step0", 32'(step0), 32'h0);
        chk_hiz("reset bus0", bus0);

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            start(vecs[i].sel);
            ram_data = vecs[i].instr;
            carry    = vecs[i].c;
            zero     = vecs[i].z;
            repeat (vecs[i].t) cyc();
            chk($sformatf("vec%0d ctrl", i), 32'(get_ctrl(vecs[i].sel)), 32'(vecs[i].exp_ctrl));
            chk($sformatf("vec%0d step", i), 32'(get_step(vecs[i].sel)), 32'(vecs[i].exp_step));
            if (vecs[i].hiz)
                chk_hiz($sformatf("vec%0d bus", i), get_bus(vecs[i].sel));
            else
                chk($sformatf("vec%0d bus", i), 32'(get_bus(vecs[i].sel)), 32'(vecs[i].exp_bus));
        end

        // Fetch of 0x1E, then LDA runs to T4 and wraps.
        start(0);
        ram_data = 8'h1E; carry = 1'b0; zero = 1'b0;
        chk("fetch t0 ctrl", 32'(ctrl0), 32'(M_CO | M_MI));
        cyc();
        chk("fetch t1 ctrl", 32'(ctrl0), 32'(M_RO | M_II | M_CE));
        chk("fetch t1 step", 32'(step0), 32'd1);
        cyc();
        chk("fetch opcode", 32'(opc0), 32'h1);
        chk("fetch step", 32'(step0), 32'd2);
        chk("fetch operand bus", 32'(bus0), 32'h0E);
        repeat (3) cyc();
        chk("lda wrap step", 32'(step0), 32'd0);
        chk("lda wrap ctrl", 32'(ctrl0), 32'(M_CO | M_MI));

        // Early end: SUB ends after T4, LDI after T2.
        start(1);
        ram_data = 8'h3F;
        repeat (4) cyc();
        chk("sub t4 ctrl", 32'(ctrl1), 32'(M_EO | M_AI | M_SU));
        cyc();
        chk("sub end step", 32'(step1), 32'd0);
        start(1);
        ram_data = 8'h57;
        repeat (3) cyc();
        chk("ldi end step", 32'(step1), 32'd0);

        // Halt holds through further clocks, cleared asynchronously by reset.
        start(0);
        ram_data = 8'hF0;
        repeat (2) cyc();
        chk("hlt t2 ctrl", 32'(ctrl0), 32'(M_HLT));
        repeat (10) cyc();
        chk("hlt hold ctrl", 32'(ctrl0), 32'(M_HLT));
        chk("hlt hold step", 32'(step0), 32'd2);
        chk("hlt hold opcode", 32'(opc0), 32'hF);
        chk_hiz("hlt hold bus", bus0);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("hlt reset ctrl", 32'(ctrl0), 32'h0);
        chk("hlt reset step", 32'(step0), 32'd0);
        @(negedge clock);
        rst_n[0] = 1'b1;
        #1;
        chk("hlt release ctrl", 32'(ctrl0), 32'(M_CO | M_MI));

        // Reset in the middle of ADD T3.
        start(0);
        ram_data = 8'h2B;
        repeat (3) cyc();
        chk("add t3 ctrl", 32'(ctrl0), 32'(M_RO | M_BI));
        #2 rst_n[0] = 1'b0;
        #1;
        chk("midreset ctrl", 32'(ctrl0), 32'h0);
        chk("midreset step", 32'(step0), 32'd0);
        chk("midreset opcode", 32'(opc0), 32'h0);
        chk_hiz("midreset bus", bus0);
        @(negedge clock);
        rst_n[0] = 1'b1;
        #1;
        chk("post reset ctrl", 32'(ctrl0), 32'(M_CO | M_MI));
        chk("post reset opcode", 32'(opc0), 32'h0);

        // Randomized instruction stream on both variants (HLT excluded).
        for (int sel = 0; sel < 2; sel++) begin
            start(sel);
            for (int n = 0; n < 30; n++) begin
                int          op;
                int          len;
                logic [3:0]  operand;
                logic [14:0] m;
                op       = int'($urandom_range(0, 14));
                operand  = 4'($urandom);
                ram_data = {4'(op), operand};
                carry    = 1'($urandom);
                zero     = 1'($urandom);
                len      = model_len(op, sel);
                for (int t = 0; t < len; t++) begin
                    m = model_ctrl(op, t, carry, zero);
                    chk($sformatf("rnd d%0d op%0h t%0d step", sel, op, t), 32'(get_step(sel)), 32'(t));
                    chk($sformatf("rnd d%0d op%0h t%0d ctrl", sel, op, t), 32'(get_ctrl(sel)), 32'(m));
                    if ((m & M_IO) != 0)
                        chk($sformatf("rnd d%0d op%0h t%0d bus", sel, op, t), 32'(get_bus(sel)), 32'({4'b0000, operand}));
                    else if ((m & M_RO) != 0)
                        chk($sformatf("rnd d%0d op%0h t%0d bus", sel, op, t), 32'(get_bus(sel)), 32'(ram_data));
                    else
                        chk_hiz($sformatf("rnd d%0d op%0h t%0d bus", sel, op, t), get_bus(sel));
                    if (t >= 2)
                        chk($sformatf("rnd d%0d op%0h t%0d opcode", sel, op, t), 32'(get_opc(sel)), 32'(op));
                    cyc();
                end
            end
            chk($sformatf("rnd d%0d final step", sel), 32'(get_step(sel)), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
